// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: two-digit BCD countdown with one-second prescaler, start/cancel/timeout.
// Optional level-sensitive pause input when COUNTDOWN_PAUSE_EN is defined.
`default_nettype none

module countdown_timer_bcd #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       cancel,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic       pause,
`endif
  output logic [8:0] seconds,
  output logic       busy,
  output logic       timeout,
  output logic       bad_load
);

  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(CLK_FREQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_q, count_d;
  logic [8:0]    seconds_q, seconds_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic          bad_load_q, bad_load_d;

  logic          pause_w;
  logic          load_ok_w;
  logic          run_w;

`ifdef COUNTDOWN_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign load_ok_w = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  // A frozen RUN neither advances the prescaler nor ticks.
  assign run_w     = (state_q == RUN) && !pause_w;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    timeout_d  = 1'b0;
    bad_load_d = 1'b0;

    if (cancel) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        presc_d = '0;
      end
    end else if (start && load_ok_w) begin
      state_d = RUN;
      count_d = load_val;
      presc_d = '0;
    end else begin
      // A rejected start leaves the countdown running as if it never happened.
      bad_load_d = start;
      if (run_w) begin
        if (presc_q == TICK_AT) begin
          presc_d = '0;
          if (count_q == 8'h00) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else if (count_q[3:0] != 4'd0) begin
            count_d = {count_q[7:4], count_q[3:0] - 4'd1};
          end else begin
            count_d = {count_q[7:4] - 4'd1, 4'd9};
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end

    seconds_d = (state_d == RUN) ? {1'b1, count_d} : 9'h000;
    busy_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      count_q    <= 8'h00;
      seconds_q  <= 9'h000;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      bad_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      seconds_q  <= seconds_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      bad_load_q <= bad_load_d;
    end
  end

  assign seconds  = seconds_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign bad_load = bad_load_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd with CLK_FREQ=4.
`default_nettype none

module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_val;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [8:0] seconds;
  logic       busy;
  logic       timeout;
  logic       bad_load;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd #(.CLK_FREQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load_val (load_val),
    .start    (start),
    .cancel   (cancel),
`ifdef COUNTDOWN_PAUSE_EN
    .pause    (pause),
`endif
    .seconds  (seconds),
    .busy     (busy),
    .timeout  (timeout),
    .bad_load (bad_load)
  );

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [8:0] s, input logic b,
                            input logic t, input logic bl);
    check({tag, ".seconds"},  seconds,        s);
    check({tag, ".busy"},     {8'h00, busy},     {8'h00, b});
    check({tag, ".timeout"},  {8'h00, timeout},  {8'h00, t});
    check({tag, ".bad_load"}, {8'h00, bad_load}, {8'h00, bl});
  endtask

  task automatic do_start(input logic [7:0] v);
    load_val = v;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  initial begin
    logic seen;
    reset = 1'b1; load_val = 8'h00; start = 1'b0; cancel = 1'b0; pause = 1'b0;
    step(2);
    check_outs("reset", 9'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);

    // 03 countdown: one value per 4 cycles, 00 held a full second
    do_start(8'h03);
    check_outs("t1.load", 9'h103, 1'b1, 1'b0, 1'b0);
    step(3); check("t1.hold3", seconds, 9'h103);
    step(1); check("t1.e4",    seconds, 9'h102);
    step(4); check("t1.e8",    seconds, 9'h101);
    step(4); check("t1.e12",   seconds, 9'h100);
    step(3); check_outs("t1.e15", 9'h100, 1'b1, 1'b0, 1'b0);
    step(1); check_outs("t1.expire", 9'h000, 1'b0, 1'b1, 1'b0);
    step(1); check_outs("t1.after", 9'h000, 1'b0, 1'b0, 1'b0);

    // BCD borrow, then restart with 00
    do_start(8'h10);
    check("t2.load10", seconds, 9'h110);
    step(4); check("t2.borrow", seconds, 9'h109);
    do_start(8'h00);
    check("t2.load00", seconds, 9'h100);
    step(3); check_outs("t2.e3", 9'h100, 1'b1, 1'b0, 1'b0);
    step(1); check_outs("t2.expire", 9'h000, 1'b0, 1'b1, 1'b0);

    // 99 upper bound
    do_start(8'h99);
    check("t2.load99", seconds, 9'h199);
    step(4); check("t2.dec99", seconds, 9'h198);
    cancel = 1'b1; step(1); cancel = 1'b0;
    check_outs("t2.cancel99", 9'h000, 1'b0, 1'b0, 1'b0);

    // Invalid loads
    do_start(8'h5A);
    check_outs("t3.bad_idle", 9'h000, 1'b0, 1'b0, 1'b1);
    step(1); check_outs("t3.bad_clr", 9'h000, 1'b0, 1'b0, 1'b0);
    do_start(8'hA0);
    check_outs("t3.bad_tens", 9'h000, 1'b0, 1'b0, 1'b1);
    do_start(8'h07);
    check("t3.load07", seconds, 9'h107);
    step(1);
    do_start(8'h5A);
    check_outs("t3.bad_run", 9'h107, 1'b1, 1'b0, 1'b1);
    step(1); check_outs("t3.run_clr", 9'h107, 1'b1, 1'b0, 1'b0);
    step(1); check("t3.undisturbed", seconds, 9'h106);

    // Cancel mid-run, never times out
    do_start(8'h05);
    step(8); check("t4.at103", seconds, 9'h103);
    cancel = 1'b1; step(1); cancel = 1'b0;
    check_outs("t4.cancel", 9'h000, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      seen = seen | timeout | busy;
    end
    check("t4.no_timeout", {8'h00, seen}, 9'h000);
    load_val = 8'h04; start = 1'b1; cancel = 1'b1;
    step(1);
    start = 1'b0; cancel = 1'b0;
    check_outs("t4.cancel_start", 9'h000, 1'b0, 1'b0, 1'b0);
    step(1); check_outs("t4.still_idle", 9'h000, 1'b0, 1'b0, 1'b0);

    // Restart on a tick edge, then reset mid-run
    do_start(8'h09);
    step(3); check("t5.pre_tick", seconds, 9'h109);
    do_start(8'h02);
    check_outs("t5.restart", 9'h102, 1'b1, 1'b0, 1'b0);
    step(3); check("t5.full_sec", seconds, 9'h102);
    step(1); check("t5.dec", seconds, 9'h101);
    reset = 1'b1; step(1); reset = 1'b0;
    check_outs("t5.reset", 9'h000, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | timeout | busy;
    end
    check("t5.idle_after_reset", {8'h00, seen}, 9'h000);

`ifdef COUNTDOWN_PAUSE_EN
    do_start(8'h02);
    step(2);
    pause = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (seconds !== 9'h102 || busy !== 1'b1) seen = 1'b1;
    end
    check("t6.frozen", {8'h00, seen}, 9'h000);
    pause = 1'b0;
    step(1); check("t6.resume1", seconds, 9'h102);
    step(1); check("t6.resume2", seconds, 9'h101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Per-operation countdown timer that drives the 9-bit `seconds` bus of the seven-segment display stage.
- Bus format: bit 8 = countdown active; bits 7:0 = two-digit BCD, range 00-99.
- The top-level controller loads a BCD start value and starts the timer, e.g. the operand-selection timeout in the matrix-operation menus.
- On expiry the block pulses `timeout` back to the controller.

Parameters:
- CLK_FREQ, 100000000, clk cycles per one-second tick; must be >= 2. Benches use 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_val  input  8  start value, BCD {tens, ones}; sampled only on an accepted start
- start  input  1  single-cycle pulse; load load_val and run
- cancel  input  1  single-cycle pulse; abort countdown, no timeout
- seconds  output  9  {active, tens[3:0], ones[3:0]}, registered; feeds the display
- busy  output  1  high while in RUN, registered
- timeout  output  1  single-cycle pulse on expiry, registered
- bad_load  output  1  single-cycle pulse when a start is rejected for non-BCD load_val

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - state=IDLE, prescaler=0, count=8'h00.
  - seconds=9'h000, busy=0, timeout=0, bad_load=0.
  - Reset overrides every other input and is valid mid-countdown.
- States:
  - IDLE: seconds=9'h000, busy=0.
  - RUN: seconds={1'b1, count}, busy=1.
- Start acceptance:
  - A start is invalid if either nibble of load_val is > 9.
  - Invalid start: state unchanged; bad_load=1 for one cycle; count, prescaler and outputs otherwise untouched. This also applies if already in RUN.
  - Valid start in IDLE or RUN: count<=load_val, prescaler<=0, state<=RUN.
  - New value visible on seconds the cycle after the start edge, so start in RUN is a restart.
- Prescaler: in RUN it increments 0..CLK_FREQ-1 and wraps to 0. tick = (prescaler==CLK_FREQ-1).
- Tick in RUN with count != 00: BCD decrement.
  - If ones != 0: ones-1.
  - Else: ones=9, tens-1.
  - Never produces a non-BCD nibble.
- Tick in RUN with count == 00:
  - state<=IDLE, timeout=1 for exactly one cycle, seconds<=9'h000, busy<=0.
- Timing: 00 is displayed for one full second before expiry.
  - Total start edge to timeout edge = (val+1)*CLK_FREQ cycles.
  - Start with load_val=00: timeout after CLK_FREQ cycles.
- Cancel:
  - In RUN: state<=IDLE, seconds<=0, prescaler<=0, no timeout.
  - In IDLE: no effect.
- Priority when events coincide: reset > cancel > start > tick.
  - cancel+start same cycle: cancel wins, start dropped, no bad_load.
  - start on a tick edge: reload wins, no decrement, no timeout.
- In IDLE the prescaler is held at 0 and there are no ticks.
- timeout and bad_load are never high in consecutive cycles from a single event.

Optional Feature:
- Macro: COUNTDOWN_PAUSE_EN
- Defined:
  - Adds input port `pause` (1 bit, level).
  - While pause=1 in RUN: prescaler and count freeze; seconds, busy and the active bit are unchanged.
  - Releasing pause resumes from the frozen prescaler value.
  - cancel, start and reset still act while paused, at normal priority.
  - pause in IDLE has no effect.
- Undefined: `pause` port absent; timer always runs in RUN.

Test Plan (CLK_FREQ=4):
1. reset=1 then 0; start with load_val=8'h03 at edge 0 -> seconds=0x103 from edge 1, 0x102 after edge 4, 0x101 after 8, 0x100 after 12; timeout=1 for one cycle after edge 16; seconds=0x000, busy=0.
2. load_val=8'h10, start -> after 4 cycles seconds=0x109 (borrow); load_val=8'h00, start -> timeout exactly 4 cycles later, no intermediate value.
3. load_val=8'h5A, start -> bad_load one cycle, busy=0, seconds=0x000; same during RUN at 0x107 -> countdown continues undisturbed.
4. Run from 8'h05; cancel at seconds=0x103 -> seconds=0x000 next cycle, no timeout ever; cancel+start same cycle -> stays IDLE.
5. Run from 8'h09; restart with 8'h02 on a tick edge -> seconds=0x102, full 4-cycle second before 0x101; reset=1 mid-RUN -> all outputs 0 next cycle.
6. COUNTDOWN_PAUSE_EN: run from 8'h02; pause for 10 cycles at prescaler=2 -> seconds constant at 0x102; after release, decrement occurs 2 cycles later.
